// File: rtl/datain_buf.sv
// Ejection-side capture buffer: stores accepted flits in order and exposes a registered read port.
// Optional macro DATAIN_BUF_DROP_NULL_EN treats all-zero valid words as idle flits.
module datain_buf #(
  parameter int DEPTH  = 30,
  parameter int AW     = 5,
  parameter int EXPECT = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [19:0]   datain,
  input  logic          in_valid,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [19:0]   rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] EXPECT_C = (AW+1)'(EXPECT);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic          drop;
  logic          word_vld;
  logic          in_range;

  logic [19:0]   mem [DEPTH];

`ifdef DATAIN_BUF_DROP_NULL_EN
  assign word_vld = in_valid && (datain != 20'h00000);
`else
  assign word_vld = in_valid;
`endif

  assign in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Next-state, fill bookkeeping and sticky flags; clear beats any incoming word.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;
    drop     = 1'b0;
    if (clear) begin
      state_d  = EMPTY;
      count_d  = '0;
      wr_ptr_d = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (word_vld) begin
      unique case (state_q)
        EMPTY, FILLING: begin
          accept   = 1'b1;
          count_d  = count_q + 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = (count_d == DEPTH_C) ? FULL : FILLING;
          if (count_d == EXPECT_C)
            done_d = 1'b1;
        end
        FULL: begin
          drop  = 1'b1;
          ovf_d = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr_q] <= datain;
  end

  // Registered read port, read-before-write against the same-cycle store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= in_range ? mem[rd_addr] : 20'h00000;
    end
  end

  assign count    = count_q;
  assign full     = (state_q == FULL);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_datain_buf.sv
// Directed bench for datain_buf: table-driven fill/read/overflow, then
// hand-written clear, read-before-write, mid-stream reset and null-word sequences.
module tb_datain_buf;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [19:0] datain;
  logic        in_valid;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic [5:0]  count;
  logic        full;
  logic        done;
  logic        overflow;

  int nvec;
  int nerr;

  datain_buf dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .datain   (datain),
    .in_valid (in_valid),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [19:0] din;
    logic        ren;
    logic [4:0]  addr;
    logic [5:0]  e_cnt;
    logic        e_full;
    logic        e_done;
    logic        e_ovf;
    logic        e_rv;
    logic [19:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [19:0] d,
                       input logic re, input logic [4:0] a,
                       input logic cl);
    in_valid = v;
    datain   = d;
    rd_en    = re;
    rd_addr  = a;
    clear    = cl;
  endtask

  task automatic idle();
    drive(1'b0, 20'h0, 1'b0, 5'd0, 1'b0);
  endtask

  function automatic vec_t mk(input logic v, input logic [19:0] d,
                              input logic re, input logic [4:0] a,
                              input int c, input logic f, input logic dn,
                              input logic o, input logic rv,
                              input logic [19:0] rd);
    vec_t t;
    t.vld = v; t.din = d; t.ren = re; t.addr = a;
    t.e_cnt = 6'(c); t.e_full = f; t.e_done = dn; t.e_ovf = o;
    t.e_rv = rv; t.e_rd = rd;
    return t;
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b0;
    idle();

    // 30 writes: done/full only on the 30th
    for (int i = 0; i < 30; i++)
      tbl.push_back(mk(1, 20'h01011 + 20'(i), 0, 0, i + 1,
                       i == 29, i == 29, 0, 0, 20'h0));
    // read back 0..29 in order
    for (int i = 0; i < 30; i++)
      tbl.push_back(mk(0, 0, 1, 5'(i), 30, 1, 1, 0, 1,
                       20'h01011 + 20'(i)));
    // rd_valid drops, rd_data holds
    tbl.push_back(mk(0, 0, 0, 0, 30, 1, 1, 0, 0, 20'h0102E));
    // extra word while full is dropped
    tbl.push_back(mk(1, 20'hABCDE, 0, 0, 30, 1, 1, 1, 0, 20'h0102E));
    // mem[29] unchanged
    tbl.push_back(mk(0, 0, 1, 5'd29, 30, 1, 1, 1, 1, 20'h0102E));
    tbl.push_back(mk(0, 0, 0, 0, 30, 1, 1, 1, 0, 20'h0102E));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.rv", 32'(rd_valid), 0);
    chk("rst.rd", 32'(rd_data), 0);
    rst = 1'b1;
    cyc();

    foreach (tbl[k]) begin
      drive(tbl[k].vld, tbl[k].din, tbl[k].ren, tbl[k].addr, 1'b0);
      cyc();
      chk($sformatf("v%0d.count", k), 32'(count), 32'(tbl[k].e_cnt));
      chk($sformatf("v%0d.full", k), 32'(full), 32'(tbl[k].e_full));
      chk($sformatf("v%0d.done", k), 32'(done), 32'(tbl[k].e_done));
      chk($sformatf("v%0d.ovf", k), 32'(overflow), 32'(tbl[k].e_ovf));
      chk($sformatf("v%0d.rv", k), 32'(rd_valid), 32'(tbl[k].e_rv));
      chk($sformatf("v%0d.rd", k), 32'(rd_data), 32'(tbl[k].e_rd));
    end

    // clear with a valid word while full: flags drop, word not counted
    drive(1'b1, 20'h02022, 1'b0, 5'd0, 1'b1);
    cyc();
    chk("clrf.count", 32'(count), 0);
    chk("clrf.full", 32'(full), 0);
    chk("clrf.done", 32'(done), 0);
    chk("clrf.ovf", 32'(overflow), 0);

    // 7 words to addresses 0..6, then write addr 7 while reading it
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 20'h03000 + 20'(i), 1'b0, 5'd0, 1'b0);
      cyc();
    end
    drive(1'b1, 20'h00420, 1'b1, 5'd7, 1'b0);
    cyc();
    chk("rbw.old", 32'(rd_data), 32'h01018);
    chk("rbw.rv", 32'(rd_valid), 1);
    chk("rbw.count", 32'(count), 8);
    drive(1'b0, 20'h0, 1'b1, 5'd7, 1'b0);
    cyc();
    chk("rbw.new", 32'(rd_data), 32'h00420);
    drive(1'b0, 20'h0, 1'b1, 5'd31, 1'b0);
    cyc();
    chk("oob31.rd", 32'(rd_data), 0);
    chk("oob31.rv", 32'(rd_valid), 1);
    drive(1'b0, 20'h0, 1'b1, 5'd6, 1'b0);
    cyc();
    chk("rd6", 32'(rd_data), 32'h03006);
    drive(1'b0, 20'h0, 1'b1, 5'd30, 1'b0);
    cyc();
    chk("oob30.rd", 32'(rd_data), 0);

    // clear does not suppress a same-cycle read
    drive(1'b0, 20'h0, 1'b1, 5'd7, 1'b1);
    cyc();
    chk("clrrd.rv", 32'(rd_valid), 1);
    chk("clrrd.rd", 32'(rd_data), 32'h00420);
    chk("clrrd.count", 32'(count), 0);

    // 5 words, then clear together with valid 0x02022
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 20'h04000 + 20'(i), 1'b0, 5'd0, 1'b0);
      cyc();
    end
    chk("five.count", 32'(count), 5);
    drive(1'b1, 20'h02022, 1'b0, 5'd0, 1'b1);
    cyc();
    chk("clr5.count", 32'(count), 0);
    chk("clr5.done", 32'(done), 0);
    chk("clr5.ovf", 32'(overflow), 0);
    chk("clr5.full", 32'(full), 0);
    drive(1'b1, 20'h05555, 1'b0, 5'd0, 1'b0);
    cyc();
    drive(1'b0, 20'h0, 1'b1, 5'd0, 1'b0);
    cyc();
    chk("clr5.addr0", 32'(rd_data), 32'h05555);
    chk("clr5.cnt1", 32'(count), 1);
    drive(1'b0, 20'h0, 1'b1, 5'd1, 1'b0);
    cyc();
    chk("clr5.addr1", 32'(rd_data), 32'h04001);

    // asynchronous reset mid-stream after 12 words
    drive(1'b0, 20'h0, 1'b0, 5'd0, 1'b1);
    cyc();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 20'h06000 + 20'(i), 1'b1, 5'd0, 1'b0);
      cyc();
    end
    chk("mid.count", 32'(count), 12);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.full", 32'(full), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.ovf", 32'(overflow), 0);
    chk("arst.rv", 32'(rd_valid), 0);
    chk("arst.rd", 32'(rd_data), 0);
    idle();
    cyc();
    rst = 1'b1;
    drive(1'b1, 20'h07777, 1'b0, 5'd0, 1'b0);
    cyc();
    chk("rest.count", 32'(count), 1);
    drive(1'b0, 20'h0, 1'b1, 5'd0, 1'b0);
    cyc();
    chk("rest.addr0", 32'(rd_data), 32'h07777);

    // null-word handling
    drive(1'b0, 20'h0, 1'b0, 5'd0, 1'b1);
    cyc();
    drive(1'b1, 20'h00000, 1'b0, 5'd0, 1'b0); cyc();
    drive(1'b1, 20'h01011, 1'b0, 5'd0, 1'b0); cyc();
    drive(1'b1, 20'h00000, 1'b0, 5'd0, 1'b0); cyc();
    drive(1'b1, 20'h02012, 1'b0, 5'd0, 1'b0); cyc();
    drive(1'b0, 20'h0, 1'b1, 5'd0, 1'b0); cyc();
`ifdef DATAIN_BUF_DROP_NULL_EN
    chk("null.count", 32'(count), 2);
    chk("null.m0", 32'(rd_data), 32'h01011);
    drive(1'b0, 20'h0, 1'b1, 5'd1, 1'b0); cyc();
    chk("null.m1", 32'(rd_data), 32'h02012);
`else
    chk("null.count", 32'(count), 4);
    chk("null.m0", 32'(rd_data), 32'h00000);
    drive(1'b0, 20'h0, 1'b1, 5'd1, 1'b0); cyc();
    chk("null.m1", 32'(rd_data), 32'h01011);
    drive(1'b0, 20'h0, 1'b1, 5'd3, 1'b0); cyc();
    chk("null.m3", 32'(rd_data), 32'h02012);
`endif
    chk("null.ovf", 32'(overflow), 0);
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
